// File: rtl/jamma_input_scanner_pkg.sv
// Shared definitions for the JAMMA input scanner: sizes, idle key value, FSM states
// and the helper that maps a mux select onto its shadow-word bit position.
package jamma_input_scanner_pkg;

  localparam int unsigned NumInputs = 16;
  localparam int unsigned SelW      = 4;

  localparam logic [SelW-1:0]      LastSel  = SelW'(NumInputs - 1);
  localparam logic [NumInputs-1:0] KeysIdle = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StCommit,
    StGap
  } scan_state_e;

  // The mux routes in[15-sel] when select=sel, so the sample lands in the mirrored bit.
  function automatic logic [NumInputs-1:0] place_bit(input logic [NumInputs-1:0] word,
                                                     input logic [SelW-1:0]      sel,
                                                     input logic                 b);
    logic [NumInputs-1:0] w;
    w = word;
    w[LastSel - sel] = b;
    return w;
  endfunction

endpackage

// File: rtl/jamma_input_scanner_debounce_16.sv
// Frame-level debouncer: keys follows a word only after DEBOUNCE_FRAMES identical frames.
module jamma_input_scanner_debounce_16
  import jamma_input_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [NumInputs-1:0] word,
  output logic [NumInputs-1:0] keys,
  output logic                 changed
);

  localparam logic [3:0] Target = 4'(DEBOUNCE_FRAMES);

  logic [NumInputs-1:0] cand_q, cand_d;
  logic [NumInputs-1:0] keys_q, keys_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 changed_q, changed_d;

  always_comb begin
    cand_d    = cand_q;
    keys_d    = keys_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;
    if (load) begin
      // Saturate at the target so a long steady input never wraps the count.
      if (word == cand_q) begin
        cnt_d = (cnt_q >= Target) ? Target : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
      cand_d = word;
      if ((cnt_d == Target) && (word != keys_q)) begin
        keys_d    = word;
        changed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q    <= KeysIdle;
      keys_q    <= KeysIdle;
      cnt_q     <= 4'd0;
      changed_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      keys_q    <= keys_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  assign keys    = keys_q;
  assign changed = changed_q;

endmodule

// File: rtl/jamma_input_scanner.sv
// Drives the 16:1 input mux select, samples each input after a settle delay, and
// publishes the raw frame and the debounced key word.
module jamma_input_scanner
  import jamma_input_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned FRAME_GAP       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mux_in,
  output logic [SelW-1:0]      select,
  output logic [NumInputs-1:0] raw,
  output logic                 raw_valid,
  output logic [NumInputs-1:0] keys,
  output logic                 keys_changed,
  output logic                 busy
);

  localparam logic [3:0]  SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  GapLast    = 8'(FRAME_GAP - 1);
  localparam scan_state_e BitStartSt = (SETTLE_CYCLES == 0) ? StSample : StSettle;

  scan_state_e          state_q, state_d;
  logic [SelW-1:0]      index_q, index_d;
  logic [3:0]           settle_q, settle_d;
  logic [7:0]           gap_q, gap_d;
  logic [NumInputs-1:0] shadow_q, shadow_d;
  logic [NumInputs-1:0] raw_q, raw_d;
  logic                 raw_valid_q, raw_valid_d;
  logic                 frame_done;
  scan_state_e          next_frame_st;

  // enable is only looked at here, at the frame boundary.
  assign next_frame_st = enable ? BitStartSt : StIdle;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    settle_d    = settle_q;
    gap_d       = gap_q;
    shadow_d    = shadow_q;
    raw_d       = raw_q;
    raw_valid_d = 1'b0;
    frame_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        index_d  = '0;
        settle_d = 4'd0;
        state_d  = next_frame_st;
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StSample: begin
        shadow_d = place_bit(shadow_q, index_q, mux_in);
        settle_d = 4'd0;
        if (index_q == LastSel) begin
          // Load on entry to COMMIT so raw, raw_valid and keys are all visible in that cycle.
          state_d     = StCommit;
          index_d     = '0;
          raw_d       = shadow_d;
          raw_valid_d = 1'b1;
          frame_done  = 1'b1;
        end else begin
          index_d = index_q + 4'd1;
          state_d = BitStartSt;
        end
      end
      StCommit: begin
        gap_d   = 8'd0;
        state_d = (FRAME_GAP == 0) ? next_frame_st : StGap;
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = next_frame_st;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      index_q     <= '0;
      settle_q    <= 4'd0;
      gap_q       <= 8'd0;
      shadow_q    <= KeysIdle;
      raw_q       <= KeysIdle;
      raw_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      settle_q    <= settle_d;
      gap_q       <= gap_d;
      shadow_q    <= shadow_d;
      raw_q       <= raw_d;
      raw_valid_q <= raw_valid_d;
    end
  end

  jamma_input_scanner_debounce_16 #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .load   (frame_done),
    .word   (shadow_d),
    .keys   (keys),
    .changed(keys_changed)
  );

  assign select    = index_q;
  assign raw       = raw_q;
  assign raw_valid = raw_valid_q;
  assign busy      = (state_q == StSettle) || (state_q == StSample) || (state_q == StCommit);

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Bench for jamma_input_scanner: a default-parameter instance and a fast instance
// (no settle, no gap, single-frame debounce), each fed by a behavioural 16:1 mux.
module tb_jamma_input_scanner;

  logic        clk = 1'b0;
  logic        reset, enable, f_enable;
  logic [15:0] in_word, f_in;
  logic        mux_in, f_mux_in;

  logic [3:0]  select, f_select;
  logic [15:0] raw, f_raw, keys, f_keys;
  logic        raw_valid, f_raw_valid, keys_changed, f_keys_changed, busy, f_busy;

  always #5 clk = ~clk;

  // Mux model: select=k routes in[15-k].
  assign mux_in   = in_word[4'd15 - select];
  assign f_mux_in = f_in[4'd15 - f_select];

  jamma_input_scanner u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mux_in      (mux_in),
    .select      (select),
    .raw         (raw),
    .raw_valid   (raw_valid),
    .keys        (keys),
    .keys_changed(keys_changed),
    .busy        (busy)
  );

  jamma_input_scanner #(
    .SETTLE_CYCLES  (0),
    .DEBOUNCE_FRAMES(1),
    .FRAME_GAP      (0)
  ) u_fast (
    .clk         (clk),
    .reset       (reset),
    .enable      (f_enable),
    .mux_in      (f_mux_in),
    .select      (f_select),
    .raw         (f_raw),
    .raw_valid   (f_raw_valid),
    .keys        (f_keys),
    .keys_changed(f_keys_changed),
    .busy        (f_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Frame-level reference: candidate word, run count and published keys per instance.
  logic [15:0] m_cand[2];
  int unsigned m_cnt[2];
  logic [15:0] m_keys[2];

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_raw;
    logic [15:0] exp_keys;
    logic        exp_chg;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cand[i] = 16'hFFFF;
      m_cnt[i]  = 0;
      m_keys[i] = 16'hFFFF;
    end
  endtask

  task automatic model_frame(input int id, input logic [15:0] w, input int unsigned d,
                             output logic chg);
    if (w == m_cand[id]) m_cnt[id] = (m_cnt[id] + 1 > d) ? d : m_cnt[id] + 1;
    else m_cnt[id] = 1;
    m_cand[id] = w;
    chg = (m_cnt[id] == d) && (w != m_keys[id]);
    if (chg) m_keys[id] = w;
  endtask

  task automatic wait_rv(input bit fast, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((fast ? f_raw_valid : raw_valid) !== 1'b1) && n < 200);
    check(fast ? "f_rv_seen" : "rv_seen", 32'(fast ? f_raw_valid : raw_valid), 32'd1);
    at = cyc_cnt;
  endtask

  task automatic frame_check(input bit fast, input logic [15:0] e_raw, input logic [15:0] e_keys,
                             input logic e_chg);
    if (fast) begin
      check("f_raw", 32'(f_raw), 32'(e_raw));
      check("f_keys", 32'(f_keys), 32'(e_keys));
      check("f_keys_changed", 32'(f_keys_changed), 32'(e_chg));
    end else begin
      check("raw", 32'(raw), 32'(e_raw));
      check("keys", 32'(keys), 32'(e_keys));
      check("keys_changed", 32'(keys_changed), 32'(e_chg));
    end
  endtask

  task automatic drop_check(input bit fast);
    @(negedge clk);
    check("pulse_width_rv", 32'(fast ? f_raw_valid : raw_valid), 32'd0);
    check("pulse_width_kc", 32'(fast ? f_keys_changed : keys_changed), 32'd0);
  endtask

  task automatic reset_values_check();
    check("rst_select", 32'(select), 32'd0);
    check("rst_raw", 32'(raw), 32'hFFFF);
    check("rst_keys", 32'(keys), 32'hFFFF);
    check("rst_raw_valid", 32'(raw_valid), 32'd0);
    check("rst_keys_changed", 32'(keys_changed), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [15:0] pick(input logic [15:0] prev);
    if ($urandom_range(0, 2) == 0) return 16'($urandom);
    return prev;
  endfunction

  initial begin
    logic [15:0] w;
    logic        chg;
    int          at, last_at, t0, seen;

    tbl[0]  = '{16'h7FFF, 16'h7FFF, 16'hFFFF, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h7FFF, 16'hFFFF, 1'b0};
    tbl[2]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[3]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[4]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[5]  = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 1'b0};
    tbl[6]  = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 1'b0};
    tbl[7]  = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 1'b1};
    tbl[8]  = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 1'b0};
    tbl[9]  = '{16'h1234, 16'h1234, 16'hFFFE, 1'b0};
    tbl[10] = '{16'h1234, 16'h1234, 16'hFFFE, 1'b0};
    tbl[11] = '{16'h1234, 16'h1234, 16'h1234, 1'b1};
    tbl[12] = '{16'h1234, 16'h1234, 16'h1234, 1'b0};

    model_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    f_enable = 1'b0;
    in_word  = 16'hFFFF;
    f_in     = 16'hFFFF;
    repeat (3) @(negedge clk);
    reset_values_check();
    check("f_rst_raw", 32'(f_raw), 32'hFFFF);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // First frame by hand: select must step every 3 clocks, commit at frame cycle 48.
    in_word = tbl[0].word;
    enable  = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      check("select_step", 32'(select), 32'(k / 3));
    end
    @(negedge clk);
    check("rv_at_cycle48", 32'(raw_valid), 32'd1);
    last_at = cyc_cnt;
    model_frame(0, tbl[0].word, 3, chg);
    frame_check(0, tbl[0].exp_raw, tbl[0].exp_keys, tbl[0].exp_chg);
    drop_check(0);

    for (int i = 1; i < 13; i++) begin
      in_word = tbl[i].word;
      wait_rv(0, at);
      check("frame_period", 32'(at - last_at), 32'd53);
      last_at = at;
      model_frame(0, tbl[i].word, 3, chg);
      frame_check(0, tbl[i].exp_raw, tbl[i].exp_keys, tbl[i].exp_chg);
      drop_check(0);
    end

    w = in_word;
    for (int r = 0; r < 10; r++) begin
      w       = pick(w);
      in_word = w;
      wait_rv(0, at);
      check("frame_period", 32'(at - last_at), 32'd53);
      last_at = at;
      model_frame(0, w, 3, chg);
      frame_check(0, w, m_keys[0], chg);
      drop_check(0);
    end

    // enable dropped at frame cycle 20: the frame still commits, then the block idles.
    w       = 16'($urandom);
    in_word = w;
    repeat (4) @(negedge clk);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    t0     = cyc_cnt;
    wait_rv(0, at);
    check("drop_commit_cycle", 32'(at - t0), 32'd28);
    model_frame(0, w, 3, chg);
    frame_check(0, w, m_keys[0], chg);
    repeat (5) @(negedge clk);
    check("drop_idle_busy", 32'(busy), 32'd0);
    check("drop_idle_select", 32'(select), 32'd0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (raw_valid || busy) seen++;
    end
    check("idle_quiet", 32'(seen), 32'd0);

    // reset at frame cycle 30 discards the partial frame.
    in_word = 16'hA5A5;
    enable  = 1'b1;
    @(negedge clk);
    check("restart_busy", 32'(busy), 32'd1);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset_values_check();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_select", 32'(select), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd1);
    t0 = cyc_cnt;
    wait_rv(0, at);
    check("post_rst_commit", 32'(at - t0), 32'd48);
    model_frame(0, 16'hA5A5, 3, chg);
    frame_check(0, 16'hA5A5, m_keys[0], chg);
    enable = 1'b0;

    // Fast instance: bit order with single-frame debounce, then back-to-back 17-clock frames.
    f_in     = 16'h8000;
    f_enable = 1'b1;
    t0       = cyc_cnt;
    wait_rv(1, at);
    check("f_first_commit", 32'(at - t0), 32'd17);
    last_at = at;
    model_frame(1, 16'h8000, 1, chg);
    frame_check(1, 16'h8000, 16'h8000, 1'b1);
    drop_check(1);

    w = 16'h8000;
    for (int r = 0; r < 10; r++) begin
      if (r > 0) w = ($urandom_range(0, 3) == 0) ? w : 16'($urandom);
      f_in = w;
      wait_rv(1, at);
      check("f_frame_period", 32'(at - last_at), 32'd17);
      last_at = at;
      model_frame(1, w, 1, chg);
      frame_check(1, w, m_keys[1], chg);
      drop_check(1);
    end
    f_enable = 1'b0;
    repeat (40) @(negedge clk);
    check("f_idle_busy", 32'(f_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jamma_input_scanner.md
Name: jamma_input_scanner

Overview:
- Sequencer that owns the select side of the 16:1 input mux: steps select 0..15, waits for the mux output to settle, then samples the single-bit mux output.
- Reassembles the samples into a 16-bit word and debounces that word across frames.
- Publishes a raw word and a stable key word to game logic.
- Sits between the JAMMA edge-connector input mux and the control/register block.

Parameters:
- SETTLE_CYCLES, 2, idle clocks after each select change before the sample; range 0..15.
- DEBOUNCE_FRAMES, 3, consecutive identical frames required before keys updates; range 1..15.
- FRAME_GAP, 4, idle clocks after commit before the next frame; range 0..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run scanning; sampled at frame boundaries only.
- mux_in  in  1  output of the 16:1 input mux.
- select  out  4  mux select.
- raw  out  16  last complete unfiltered frame.
- raw_valid  out  1  one-cycle pulse when raw updates.
- keys  out  16  debounced input word; active-low, idle all ones.
- keys_changed  out  1  one-cycle pulse when keys updates.
- busy  out  1  high while a frame is in progress (SETTLE, SAMPLE or COMMIT).

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; all registers load on the clk edge while reset=1.
- Reset values:
  - select=0, raw=16'hFFFF, keys=16'hFFFF, raw_valid=0, keys_changed=0, busy=0.
  - shadow word=16'hFFFF, candidate=16'hFFFF, debounce count=0, state=IDLE.
- Bit mapping matches the mux: select=k routes in[15-k], so the sample taken at select=k is stored in shadow[15-k].
- State machine:
  - IDLE: select=0. If enable=1 go to SETTLE with bit index=0 and settle counter=0.
  - SETTLE: hold select=index. Increment the settle counter. When counter==SETTLE_CYCLES go to SAMPLE; with SETTLE_CYCLES=0, SETTLE lasts 0 cycles and goes straight to SAMPLE.
  - SAMPLE, one cycle: shadow[15-index]<=mux_in.
    - If index==15, go to COMMIT.
    - Otherwise index++, select<=index+1, go to SETTLE.
  - COMMIT, one cycle: raw<=shadow, raw_valid=1, debounce update; then go to GAP.
  - GAP: count FRAME_GAP cycles. Then go to SETTLE with index=0 if enable=1, else go to IDLE. With FRAME_GAP=0, GAP lasts 0 cycles.
- Timing: bit period is SETTLE_CYCLES+1 clocks; frame is 16*(SETTLE_CYCLES+1)+1 clocks. With the defaults, the sample for bit k is taken at frame cycle 3k+2, commit is at cycle 48, and the next frame starts at cycle 53.
- Debounce, evaluated at COMMIT:
  - next_cnt = (shadow==candidate) ? min(cnt+1, DEBOUNCE_FRAMES) : 1.
  - candidate<=shadow; cnt<=next_cnt.
  - If next_cnt==DEBOUNCE_FRAMES and shadow!=keys: keys<=shadow and keys_changed=1 in the same cycle as raw_valid.
  - DEBOUNCE_FRAMES=1 makes keys follow every frame.
  - The count saturates and never wraps.
- Boundary conditions:
  - enable dropped mid-frame: the current frame completes, including COMMIT, then the block enters IDLE.
  - enable toggled during GAP: only its value at the end of GAP matters.
  - reset mid-frame: the partial shadow is discarded, outputs return to reset values, and no raw_valid pulse is issued.
  - A frame identical to keys only refreshes the count; keys_changed is not pulsed.
- raw_valid and keys_changed are never high for more than one cycle.

Decomposition:
- Shared include scan_defs.vh: state localparams (IDLE, SETTLE, SAMPLE, COMMIT, GAP), NUM_INPUTS=16, SEL_W=4, KEYS_IDLE=16'hFFFF.
- Sub-module debounce_16 (parameter DEBOUNCE_FRAMES):
  - Inputs: clk, reset, load, word[15:0].
  - Outputs: keys[15:0], changed.
  - Holds candidate, count and keys.
- The top level holds the FSM, the counters and the shadow word.

Test Plan:
- Reset, then enable=1 with a mux model driving in=16'hFFFE under defaults -> select steps 0..15 every 3 clocks; raw_valid pulses at cycle 48 with raw=16'hFFFE; keys stays 16'hFFFF through frames 1-2; keys=16'hFFFE with keys_changed pulsing at frame-3 commit.
- Bit order check: in=16'h8000 with DEBOUNCE_FRAMES=1 -> raw=16'h8000, which must be the value sampled while select=0.
- Glitch: in=16'h7FFF for 2 frames, then back to 16'hFFFF -> keys never changes and keys_changed never pulses.
- enable deasserted at frame cycle 20 -> the frame finishes, raw_valid pulses at cycle 48, then IDLE with select=0 and busy=0.
- reset asserted at frame cycle 30 -> next cycle all outputs are at reset values with no raw_valid; after release and enable, a full frame restarts at select=0.
- SETTLE_CYCLES=0, FRAME_GAP=0 -> frame is 17 clocks; frames run back-to-back with raw_valid every 17 cycles.
